// File: rtl/lspcu_axi.sv
// lspcu_axi: turns single-beat LSU load/store requests into AXI4-Lite transactions, one outstanding.
// Optional feature macro LSPCU_PERF_COUNTER_EN adds rd_count, wr_count and stall_cycles outputs.
module lspcu_axi #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rd_req_valid,
   input  logic [ADDR_W-1:0]   rd_req_addr,
   input  logic                wr_req_valid,
   input  logic [ADDR_W-1:0]   wr_req_addr,
   input  logic [DATA_W-1:0]   wr_req_data,
   input  logic [DATA_W/8-1:0] wr_req_strb,
   output logic                rd_resp_valid,
   output logic [DATA_W-1:0]   rd_resp_data,
   output logic                wr_resp_valid,
   output logic                bus_err,
   output logic                busy,
`ifdef LSPCU_PERF_COUNTER_EN
   output logic [63:0]         rd_count,
   output logic [63:0]         wr_count,
   output logic [63:0]         stall_cycles,
`endif
   output logic [ADDR_W-1:0]   araddr,
   output logic                arvalid,
   input  logic                arready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rvalid,
   output logic                rready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready
);

   localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_WR_RESP = 3'd4
   } state_t;

   state_t state_r, state_nxt_s;

   logic [ADDR_W-1:0]   addr_r;
   logic [DATA_W-1:0]   data_r;
   logic [DATA_W/8-1:0] strb_r;
   logic                aw_done_r, w_done_r;
   logic                aw_done_nxt_s, w_done_nxt_s;

   logic rd_accept_s, wr_accept_s;
   logic ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;

   logic                arvalid_r, rready_r, awvalid_r, wvalid_r, bready_r;
   logic                rd_resp_valid_r, wr_resp_valid_r, bus_err_r, busy_r;
   logic [DATA_W-1:0]   rd_resp_data_r;
   logic                arvalid_nxt_s, rready_nxt_s, awvalid_nxt_s, wvalid_nxt_s, bready_nxt_s;
   logic                rd_resp_valid_nxt_s, wr_resp_valid_nxt_s, bus_err_nxt_s, busy_nxt_s;
   logic [DATA_W-1:0]   rd_resp_data_nxt_s;

   // A read wins when both request valids are high in IDLE.
   assign rd_accept_s = (state_r == ST_IDLE) && rd_req_valid;
   assign wr_accept_s = (state_r == ST_IDLE) && wr_req_valid && !rd_req_valid;
   assign ar_hs_s     = arvalid_r & arready;
   assign r_hs_s      = rready_r & rvalid;
   assign aw_hs_s     = awvalid_r & awready;
   assign w_hs_s      = wvalid_r & wready;
   assign b_hs_s      = bready_r & bvalid;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Write-channel done flags, including handshakes completing this cycle.
   always_comb begin
      if (state_r == ST_WR_REQ) begin
         aw_done_nxt_s = aw_done_r | aw_hs_s;
         w_done_nxt_s  = w_done_r | w_hs_s;
      end else begin
         aw_done_nxt_s = 1'b0;
         w_done_nxt_s  = 1'b0;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (rd_accept_s) begin
               state_nxt_s = ST_RD_ADDR;
            end else if (wr_accept_s) begin
               state_nxt_s = ST_WR_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RD_ADDR: begin
            if (ar_hs_s) state_nxt_s = ST_RD_DATA;
            else         state_nxt_s = ST_RD_ADDR;
         end
         ST_RD_DATA: begin
            if (r_hs_s) state_nxt_s = ST_IDLE;
            else        state_nxt_s = ST_RD_DATA;
         end
         ST_WR_REQ: begin
            if (aw_done_nxt_s && w_done_nxt_s) state_nxt_s = ST_WR_RESP;
            else                               state_nxt_s = ST_WR_REQ;
         end
         ST_WR_RESP: begin
            if (b_hs_s) state_nxt_s = ST_IDLE;
            else        state_nxt_s = ST_WR_RESP;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output logic: next values of all registered outputs, keyed off the upcoming state.
   always_comb begin
      arvalid_nxt_s       = (state_nxt_s == ST_RD_ADDR);
      rready_nxt_s        = (state_nxt_s == ST_RD_DATA);
      awvalid_nxt_s       = (state_nxt_s == ST_WR_REQ) && !aw_done_nxt_s;
      wvalid_nxt_s        = (state_nxt_s == ST_WR_REQ) && !w_done_nxt_s;
      bready_nxt_s        = (state_nxt_s == ST_WR_RESP);
      busy_nxt_s          = (state_nxt_s != ST_IDLE);
      rd_resp_valid_nxt_s = r_hs_s;
      wr_resp_valid_nxt_s = b_hs_s;
      if (r_hs_s) begin
         bus_err_nxt_s      = (rresp != 2'b00);
         rd_resp_data_nxt_s = rdata;
      end else if (b_hs_s) begin
         bus_err_nxt_s      = (bresp != 2'b00);
         rd_resp_data_nxt_s = rd_resp_data_r;
      end else begin
         bus_err_nxt_s      = 1'b0;
         rd_resp_data_nxt_s = rd_resp_data_r;
      end
   end

   // Output and done-flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         arvalid_r       <= 1'b0;
         rready_r        <= 1'b0;
         awvalid_r       <= 1'b0;
         wvalid_r        <= 1'b0;
         bready_r        <= 1'b0;
         rd_resp_valid_r <= 1'b0;
         wr_resp_valid_r <= 1'b0;
         bus_err_r       <= 1'b0;
         busy_r          <= 1'b0;
         rd_resp_data_r  <= {DATA_W{1'b0}};
         aw_done_r       <= 1'b0;
         w_done_r        <= 1'b0;
      end else begin
         arvalid_r       <= arvalid_nxt_s;
         rready_r        <= rready_nxt_s;
         awvalid_r       <= awvalid_nxt_s;
         wvalid_r        <= wvalid_nxt_s;
         bready_r        <= bready_nxt_s;
         rd_resp_valid_r <= rd_resp_valid_nxt_s;
         wr_resp_valid_r <= wr_resp_valid_nxt_s;
         bus_err_r       <= bus_err_nxt_s;
         busy_r          <= busy_nxt_s;
         rd_resp_data_r  <= rd_resp_data_nxt_s;
         aw_done_r       <= aw_done_nxt_s;
         w_done_r        <= w_done_nxt_s;
      end
   end

   // Request payload latch; the AXI address always carries the word-aligned form.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r <= {ADDR_W{1'b0}};
         data_r <= {DATA_W{1'b0}};
         strb_r <= {(DATA_W/8){1'b0}};
      end else if (rd_accept_s) begin
         addr_r <= rd_req_addr & WORD_MASK;
      end else if (wr_accept_s) begin
         addr_r <= wr_req_addr & WORD_MASK;
         data_r <= wr_req_data;
         strb_r <= wr_req_strb;
      end else begin
         addr_r <= addr_r;
         data_r <= data_r;
         strb_r <= strb_r;
      end
   end

   assign araddr        = addr_r;
   assign awaddr        = addr_r;
   assign wdata         = data_r;
   assign wstrb         = strb_r;
   assign arvalid       = arvalid_r;
   assign rready        = rready_r;
   assign awvalid       = awvalid_r;
   assign wvalid        = wvalid_r;
   assign bready        = bready_r;
   assign rd_resp_valid = rd_resp_valid_r;
   assign rd_resp_data  = rd_resp_data_r;
   assign wr_resp_valid = wr_resp_valid_r;
   assign bus_err       = bus_err_r;
   assign busy          = busy_r;

`ifdef LSPCU_PERF_COUNTER_EN
   logic [63:0] rd_count_r, wr_count_r, stall_cycles_r;

   // Performance counters; a transaction's stall time includes its accepting IDLE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count_r     <= 64'd0;
         wr_count_r     <= 64'd0;
         stall_cycles_r <= 64'd0;
      end else begin
         if (rd_accept_s) rd_count_r <= rd_count_r + 64'd1;
         else             rd_count_r <= rd_count_r;
         if (wr_accept_s) wr_count_r <= wr_count_r + 64'd1;
         else             wr_count_r <= wr_count_r;
         if (busy_r || rd_accept_s || wr_accept_s) stall_cycles_r <= stall_cycles_r + 64'd1;
         else                                      stall_cycles_r <= stall_cycles_r;
      end
   end

   assign rd_count     = rd_count_r;
   assign wr_count     = wr_count_r;
   assign stall_cycles = stall_cycles_r;
`endif

endmodule

// File: tb/tb_lspcu_axi.sv
// Self-checking bench for lspcu_axi: directed AXI4-Lite slave schedules plus a response scoreboard.
`timescale 1ns/1ps
module tb_lspcu_axi;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_req_valid, wr_req_valid;
   logic [31:0] rd_req_addr, wr_req_addr, wr_req_data;
   logic [3:0]  wr_req_strb;
   logic        rd_resp_valid, wr_resp_valid, bus_err, busy;
   logic [31:0] rd_resp_data;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
   logic [1:0]  rresp, bresp;
   logic [3:0]  wstrb;
`ifdef LSPCU_PERF_COUNTER_EN
   logic [63:0] rd_count, wr_count, stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        is_rd;
      logic [31:0] data;
      logic        err;
   } resp_t;
   resp_t       exp_q[$];
   logic [31:0] exp_araddr = 32'd0;
   logic [31:0] exp_awaddr = 32'd0;

   lspcu_axi dut (
      .clk(clk), .rst(rst),
      .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
      .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr),
      .wr_req_data(wr_req_data), .wr_req_strb(wr_req_strb),
      .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
      .wr_resp_valid(wr_resp_valid), .bus_err(bus_err), .busy(busy),
`ifdef LSPCU_PERF_COUNTER_EN
      .rd_count(rd_count), .wr_count(wr_count), .stall_cycles(stall_cycles),
`endif
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle compare: responses against the scoreboard, AXI valid/payload hold rules, address model.
   logic        prev_rst = 1'b1;
   logic        prev_arvalid = 1'b0, prev_arready = 1'b0;
   logic        prev_awvalid = 1'b0, prev_awready = 1'b0;
   logic        prev_wvalid = 1'b0, prev_wready = 1'b0;
   logic [31:0] prev_araddr = 32'd0, prev_awaddr = 32'd0, prev_wdata = 32'd0;
   logic [3:0]  prev_wstrb = 4'd0;
   resp_t       cur_e;

   always @(negedge clk) begin
      if (!rst && !prev_rst) begin
         if (rd_resp_valid || wr_resp_valid) begin
            chk("resp_exclusive", rd_resp_valid & wr_resp_valid, 1'b0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp actual rd=%0b wr=%0b expected no response t=%0t",
                        rd_resp_valid, wr_resp_valid, $time);
            end else begin
               cur_e = exp_q.pop_front();
               chk("resp_kind", rd_resp_valid, cur_e.is_rd);
               chk("resp_bus_err", bus_err, cur_e.err);
               if (cur_e.is_rd) chk("resp_rd_data", rd_resp_data, cur_e.data);
            end
         end else begin
            chk("bus_err_without_resp", bus_err, 1'b0);
         end
         if (prev_arvalid && !prev_arready) begin
            chk("arvalid_hold", arvalid, 1'b1);
            chk("araddr_stable", araddr, prev_araddr);
         end
         if (prev_awvalid && !prev_awready) begin
            chk("awvalid_hold", awvalid, 1'b1);
            chk("awaddr_stable", awaddr, prev_awaddr);
         end
         if (prev_wvalid && !prev_wready) begin
            chk("wvalid_hold", wvalid, 1'b1);
            chk("wdata_stable", wdata, prev_wdata);
            chk("wstrb_stable", wstrb, prev_wstrb);
         end
         if (arvalid) chk("araddr_model", araddr, exp_araddr);
         if (awvalid) chk("awaddr_model", awaddr, exp_awaddr);
      end
      prev_rst     <= rst;
      prev_arvalid <= arvalid;
      prev_arready <= arready;
      prev_awvalid <= awvalid;
      prev_awready <= awready;
      prev_wvalid  <= wvalid;
      prev_wready  <= wready;
      prev_araddr  <= araddr;
      prev_awaddr  <= awaddr;
      prev_wdata   <= wdata;
      prev_wstrb   <= wstrb;
   end

   // Read: request in cycle 0, AR accepted after ar_wait stalls, R returned after r_wait more cycles.
   task automatic read_txn(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                           input int ar_wait, input int r_wait, input int exp_lat);
      int cyc;
      rd_req_valid = 1'b1;
      rd_req_addr  = addr;
      exp_araddr   = addr & 32'hFFFF_FFFC;
      exp_q.push_back({1'b1, data, resp != 2'b00});
      tick();
      cyc = 1;
      rd_req_valid = 1'b0;
      rd_req_addr  = 32'hFFFF_FFFF;
      chk("rd_prev_pulse_end", rd_resp_valid | wr_resp_valid, 1'b0);
      chk("rd_busy", busy, 1'b1);
      for (int i = 0; i < ar_wait; i++) begin
         chk("arvalid_stall", arvalid, 1'b1);
         tick();
         cyc++;
      end
      chk("arvalid", arvalid, 1'b1);
      chk("araddr", araddr, addr & 32'hFFFF_FFFC);
      arready = 1'b1;
      tick();
      cyc++;
      arready = 1'b0;
      chk("arvalid_drop", arvalid, 1'b0);
      for (int i = 0; i < r_wait; i++) begin
         chk("rready_wait", rready, 1'b1);
         tick();
         cyc++;
      end
      chk("rready", rready, 1'b1);
      rvalid = 1'b1;
      rdata  = data;
      rresp  = resp;
      tick();
      cyc++;
      rvalid = 1'b0;
      rdata  = 32'hFFFF_FFFF;
      rresp  = 2'b00;
      chk("rd_resp_valid", rd_resp_valid, 1'b1);
      chk("rd_resp_data", rd_resp_data, data);
      chk("rd_bus_err", bus_err, resp != 2'b00);
      chk("rd_latency", cyc, exp_lat);
      chk("rd_idle_busy", busy, 1'b0);
   endtask

   // Write: AW ready in cycle aw_wait+1, W ready in cycle w_wait+1, B after b_wait cycles in WR_RESP.
   task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] resp, input int aw_wait, input int w_wait,
                            input int b_wait, input int exp_lat);
      int   cyc;
      logic awd, wd;
      wr_req_valid = 1'b1;
      wr_req_addr  = addr;
      wr_req_data  = data;
      wr_req_strb  = strb;
      exp_awaddr   = addr & 32'hFFFF_FFFC;
      exp_q.push_back({1'b0, 32'd0, resp != 2'b00});
      tick();
      cyc = 1;
      wr_req_valid = 1'b0;
      wr_req_data  = ~data;
      wr_req_strb  = ~strb;
      chk("wr_prev_pulse_end", rd_resp_valid | wr_resp_valid, 1'b0);
      chk("awaddr", awaddr, addr & 32'hFFFF_FFFC);
      awd = 1'b0;
      wd  = 1'b0;
      while (!(awd && wd) && cyc < 64) begin
         chk("awvalid", awvalid, !awd);
         chk("wvalid", wvalid, !wd);
         if (!wd) begin
            chk("wdata", wdata, data);
            chk("wstrb", wstrb, strb);
         end
         awready = (cyc == aw_wait + 1);
         wready  = (cyc == w_wait + 1);
         tick();
         if (awready) awd = 1'b1;
         if (wready)  wd  = 1'b1;
         awready = 1'b0;
         wready  = 1'b0;
         cyc++;
      end
      chk("aw_w_done_valids", {awvalid, wvalid}, 2'b00);
      chk("bready", bready, 1'b1);
      for (int i = 0; i < b_wait; i++) begin
         tick();
         cyc++;
         chk("bready_wait", bready, 1'b1);
      end
      bvalid = 1'b1;
      bresp  = resp;
      tick();
      cyc++;
      bvalid = 1'b0;
      bresp  = 2'b00;
      chk("wr_resp_valid", wr_resp_valid, 1'b1);
      chk("wr_bus_err", bus_err, resp != 2'b00);
      chk("wr_latency", cyc, exp_lat);
      chk("wr_idle_busy", busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      rd_req_valid = 1'b0; rd_req_addr = 32'd0;
      wr_req_valid = 1'b0; wr_req_addr = 32'd0; wr_req_data = 32'd0; wr_req_strb = 4'd0;
      arready = 1'b0; rvalid = 1'b0; rdata = 32'hFFFF_FFFF; rresp = 2'b00;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      repeat (3) tick();
      chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
      chk("rst_resp", {rd_resp_valid, wr_resp_valid, bus_err, busy}, 4'b0);
      chk("rst_rd_resp_data", rd_resp_data, 32'd0);
      chk("rst_addr", {araddr, awaddr}, 64'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_wstrb", wstrb, 4'd0);
      rst = 1'b0;
      tick();

      read_txn(32'h8000_0006, 32'hDEAD_BEEF, 2'b00, 0, 0, 3);
      write_txn(32'h0000_0100, 32'h0000_AB00, 4'b0010, 2'b00, 3, 0, 0, 6);
      read_txn(32'h0000_0040, 32'h0000_1234, 2'b10, 0, 0, 3);
      write_txn(32'h0000_0203, 32'h1122_3344, 4'b1100, 2'b11, 0, 2, 1, 6);
      read_txn(32'h0000_0FFF, 32'hCAFE_F00D, 2'b01, 2, 1, 6);

      // Reset while waiting for R; the late rvalid must produce nothing.
      rd_req_valid = 1'b1;
      rd_req_addr  = 32'h0000_0300;
      exp_araddr   = 32'h0000_0300;
      tick();
      rd_req_valid = 1'b0;
      arready = 1'b1;
      tick();
      arready = 1'b0;
      chk("midrst_in_rd_data", rready, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rvalid = 1'b1;
      rdata  = 32'h5555_5555;
      chk("midrst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_no_resp", rd_resp_valid, 1'b0);
      chk("midrst_rd_data", rd_resp_data, 32'd0);
      tick();
      rvalid = 1'b0;
      rdata  = 32'hFFFF_FFFF;
      chk("midrst_late_rvalid", rd_resp_valid, 1'b0);
      chk("midrst_still_idle", {busy, arvalid, rready}, 3'b000);
      tick();

      read_txn(32'h2000_0008, 32'hA5A5_5A5A, 2'b00, 0, 0, 3);
      write_txn(32'h0000_0010, 32'hFFFF_0000, 4'b1111, 2'b00, 0, 0, 0, 3);
      tick();

`ifdef LSPCU_PERF_COUNTER_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("perf_rst", rd_count | wr_count | stall_cycles, 64'd0);
      read_txn(32'h0000_0004, 32'h0000_0001, 2'b00, 0, 0, 3);
      read_txn(32'h0000_0008, 32'h0000_0002, 2'b00, 0, 0, 3);
      write_txn(32'h0000_000C, 32'h0000_0003, 4'b0001, 2'b00, 0, 0, 0, 3);
      chk("perf_rd_count", rd_count, 64'd2);
      chk("perf_wr_count", wr_count, 64'd1);
      chk("perf_stall_cycles", stall_cycles, 64'd9);
      tick();
`endif

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      checks++;
      errors++;
      $display("FAIL timeout actual=still running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
